// File: rtl/scrambler_seq_ctrl_if.sv
// Handshake and datapath bundle for scrambler_seq_ctrl.
//   start/seed/abort       : frame control from the word source side
//   in_valid/in_data/in_ready   : input word handshake, 16 bits per beat
//   lfsr_load/lfsr_serial/lfsr_out : link to the combinational LFSR step logic
//   out_valid/out_state/out_ready  : final-state handshake to the consumer
//   busy/word_cnt          : status
// slave is the controller's view; master is the view of whatever drives it.
interface scrambler_seq_ctrl_if #(
  parameter int unsigned STATE_W = 301
) ();
  logic               start;
  logic [STATE_W-1:0] seed;
  logic               abort;
  logic               in_valid;
  logic [15:0]        in_data;
  logic               in_ready;
  logic [STATE_W-1:0] lfsr_load;
  logic [15:0]        lfsr_serial;
  logic [STATE_W-1:0] lfsr_out;
  logic               out_valid;
  logic [STATE_W-1:0] out_state;
  logic               out_ready;
  logic               busy;
  logic [15:0]        word_cnt;

  modport slave (
    input  start, seed, abort, in_valid, in_data, lfsr_out, out_ready,
    output in_ready, lfsr_load, lfsr_serial, out_valid, out_state, busy, word_cnt
  );

  modport master (
    output start, seed, abort, in_valid, in_data, lfsr_out, out_ready,
    input  in_ready, lfsr_load, lfsr_serial, out_valid, out_state, busy, word_cnt
  );
endinterface

// File: rtl/scrambler_seq_ctrl.sv
// Frame sequencer for the 301-bit, 16-bit-per-cycle LFSR scrambler datapath.
// Owns the scrambler state register: loads a seed on start, advances it by one
// datapath step per accepted input word, and presents the final state once
// FRAME_WORDS words have been consumed.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : scrambler_seq_ctrl_if.slave (frame control, input/output handshakes,
//          datapath link lfsr_load/lfsr_serial/lfsr_out, busy/word_cnt status)
module scrambler_seq_ctrl #(
  parameter int unsigned FRAME_WORDS = 19,
  parameter int unsigned STATE_W     = 301
) (
  input logic                 clk,
  input logic                 rst,
  scrambler_seq_ctrl_if.slave bus
);

  localparam logic [15:0] LastWord = 16'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} fsm_e;

  fsm_e               fsm_q;
  logic [STATE_W-1:0] lfsr_q;
  logic [15:0]        cnt_q;

  // abort outranks every transition; it clears the count but keeps lfsr_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q  <= StIdle;
      lfsr_q <= '0;
      cnt_q  <= '0;
    end else if (bus.abort) begin
      fsm_q <= StIdle;
      cnt_q <= '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (bus.start) begin
            lfsr_q <= bus.seed;
            cnt_q  <= '0;
            fsm_q  <= StLoad;
          end
        end
        StLoad: fsm_q <= StRun;
        StRun: begin
          if (bus.in_valid) begin
            lfsr_q <= bus.lfsr_out;
            cnt_q  <= cnt_q + 16'd1;
            if (cnt_q == LastWord) fsm_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) fsm_q <= StIdle;
        end
      endcase
    end
  end

  // Handshake flags depend on registered state only (plus abort gating in_ready).
  assign bus.in_ready    = (fsm_q == StRun) && !bus.abort;
  assign bus.out_valid   = (fsm_q == StDone);
  assign bus.busy        = (fsm_q != StIdle);
  assign bus.word_cnt    = cnt_q;
  assign bus.lfsr_load   = lfsr_q;
  assign bus.lfsr_serial = bus.in_data;
  assign bus.out_state   = lfsr_q;

endmodule

// File: doc/scrambler_seq_ctrl.md
# scrambler_seq_ctrl

Frame sequencer for the 301-bit, 16-bit-per-cycle LFSR scrambler datapath. It owns the scrambler state register, loads a seed at frame start, and feeds exactly FRAME_WORDS 16-bit input words through the combinational LFSR step under a valid/ready handshake. It then presents the final 301-bit state under an output valid/ready handshake. It sits between the word source and the downstream consumer, and the LFSR step logic is instantiated alongside it.

## Interface
- FRAME_WORDS, default 19: input words per frame, legal range 1..65535.
- STATE_W, default 301: LFSR state width, fixed to match the datapath.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle frame start request; honoured only in IDLE.
- seed  in  301  initial LFSR state, sampled on an accepted start.
- abort  in  1  drops the current frame and returns to IDLE.
- in_valid  in  1  in_data is valid.
- in_data  in  16  scrambler input word; bit i feeds LFSR step i, bit 0 first.
- in_ready  out  1  controller accepts in_data this cycle.
- lfsr_load  out  301  current state register, drives the datapath data_load.
- lfsr_serial  out  16  equals in_data, drives the datapath serial_in.
- lfsr_out  in  301  datapath result after 16 steps.
- out_valid  out  1  final frame state is available.
- out_state  out  301  final state, stable while out_valid is high.
- out_ready  in  1  consumer takes out_state.
- busy  out  1  high in LOAD, RUN and DONE.
- word_cnt  out  16  words accepted in the current frame.

## Operation
- The FSM has four states: IDLE, LOAD, RUN and DONE.
- IDLE:
  - If start is high, the state register takes seed, word_cnt is cleared to 0, and the FSM moves to LOAD.
- LOAD: a one-cycle settle state that unconditionally moves to RUN.
- RUN:
  - in_ready is 1.
  - On each in_valid && in_ready, the state register takes lfsr_out and word_cnt increments by 1.
  - When the accepted word is number FRAME_WORDS (word_cnt == FRAME_WORDS-1 before the increment), the FSM moves to DONE.
  - With no in_valid, the state and count hold.
- DONE:
  - out_valid is 1 and out_state equals the state register.
  - On out_ready the FSM moves to IDLE, with out_valid low on the next cycle.
  - Holds indefinitely without out_ready.
- abort is checked every cycle and has priority over every other transition.
  - Any state goes to IDLE, and word_cnt is cleared.
  - The state register is left unchanged.
  - A word presented in the same cycle as abort is not accepted (in_ready is forced to 0).
- start outside IDLE is ignored and is not queued.
- The state register updates only on seed load or on an accepted word; lfsr_out is ignored otherwise.
- word_cnt is 16 bits wide and cannot wrap, because FRAME_WORDS ≤ 65535.

## Timing
- Reset values:
  - FSM is IDLE.
  - State register is all zeros, so lfsr_load = 0 and out_state = 0.
  - word_cnt = 0.
  - in_ready, out_valid and busy are 0.
- in_ready, out_valid and busy are decoded from registered FSM state only, with no combinational path from in_valid or out_ready.
  - in_ready = (state == RUN) && !abort.
- Cycle sequence for a frame:
  - start is accepted in cycle t.
  - LOAD is cycle t+1.
  - The first word can be accepted in cycle t+2.
  - With in_valid held high, the last word is accepted in cycle t+1+FRAME_WORDS.
  - out_valid rises in cycle t+2+FRAME_WORDS.
- Minimum frame period is FRAME_WORDS+3 cycles when out_ready is tied high.
- Reset asserted mid-frame clears everything immediately, without waiting for a clock edge.
  - Deassertion is synchronised externally.
- Throughput is one 16-bit word per cycle; the combinational LFSR path is a single cycle.

## Test plan
- Zero frame: seed = 0, FRAME_WORDS = 19, 19 zero words, out_ready = 1 → out_valid is high for 1 cycle at t+21 and out_state = 0.
- Single step: FRAME_WORDS = 1, seed = 1<<300, in_data = 16'h0000 → out_state has only bits {15, 196, 224, 230} set.
- Backpressure and stalls: in_valid toggles 1/0 and out_ready is held low for 5 cycles → word_cnt counts only handshakes, and out_valid and out_state hold stable for the full 5 cycles.
- Abort mid-RUN: abort asserted after 7 of 19 words with in_valid high → in_ready = 0 in the abort cycle, the FSM enters IDLE, word_cnt = 0, and no out_valid is produced.
- Start while busy: a second start pulse during RUN → it is ignored and the frame completes with the original seed; a new start in IDLE the cycle after DONE exits is accepted.
- Async reset mid-frame: rst driven low between clock edges in RUN → busy, in_ready, out_valid and word_cnt go to 0 immediately, and lfsr_load goes to 0.
